// File: rtl/msk_and_pini_lanes_pkg.sv
// msk_and_pini_lanes_pkg: share-count helpers and random-index map for the masked AND lanes
package msk_and_pini_lanes_pkg;
  localparam int MSK_D_DEF = 2;
  typedef logic [MSK_D_DEF-1:0] msk_shares_t;
  function automatic int msk_nrnd(input int d);
    return d * (d - 1) / 2;
  endfunction
  function automatic int msk_ridx(input int d, input int i, input int j);
    return i * d - i * (i + 1) / 2 + (j - 1 - i);
  endfunction
endpackage

// File: rtl/msk_and_pini_lanes_if.sv
// msk_and_pini_lanes_if: valid/ready share bus for the masked AND lanes
interface msk_and_pini_lanes_if
  import msk_and_pini_lanes_pkg::*;
#(parameter int D = 2, parameter int N = 4);
  localparam int NRND = msk_nrnd(D);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [N*D-1:0] ina, inb, out;
  logic [N*NRND-1:0] rnd;
  modport master(output in_valid, ina, inb, rnd, out_ready, input in_ready, out_valid, out);
  modport slave(input in_valid, ina, inb, rnd, out_ready, output in_ready, out_valid, out);
endinterface

// File: rtl/msk_and_pini_lanes_lane.sv
// msk_and_pini_lanes_lane: one lane's two-stage d-share PINI AND datapath
module msk_and_pini_lanes_lane
  import msk_and_pini_lanes_pkg::*;
#(
  parameter int D = 2,
  localparam int NRND = msk_nrnd(D)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en1_i,
  input  logic            en2_i,
  input  logic            clr1_i,
  input  logic            clr2_i,
  input  logic [D-1:0]    a_i,
  input  logic [D-1:0]    b_i,
  input  logic [NRND-1:0] r_i,
  output logic [D-1:0]    out_o
);
  (* keep = "true", preserve = "true" *) logic [D-1:0] a1_q, b1_q, p2_q;
  (* keep = "true", preserve = "true" *) logic [D-1:0][D-1:0] r1_q, v1_q, u2_q, w2_q;
  logic [D-1:0][D-1:0] r1_d, v1_d, u2_d, w2_d;
  logic [D-1:0] p2_d;
  for (genvar i = 0; i < D; i++) begin : g_i
    for (genvar j = 0; j < D; j++) begin : g_j
      if (i == j) begin : g_diag
        assign r1_d[i][j] = 1'b0;
        assign v1_d[i][j] = 1'b0;
      end else begin : g_off
        localparam int K = i < j ? msk_ridx(D, i, j) : msk_ridx(D, j, i);
        assign r1_d[i][j] = r_i[K];
        assign v1_d[i][j] = b_i[j] ^ r_i[K];
      end
      assign u2_d[i][j] = ~a1_q[i] & r1_q[i][j];
      assign w2_d[i][j] = a1_q[i] & v1_q[i][j];
    end
    assign p2_d[i] = a1_q[i] & b1_q[i];
    // only XORs after the registers so no glitchy recombination of shares
    assign out_o[i] = p2_q[i] ^ (^u2_q[i]) ^ (^w2_q[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q <= '0;
      b1_q <= '0;
      r1_q <= '0;
      v1_q <= '0;
      p2_q <= '0;
      u2_q <= '0;
      w2_q <= '0;
    end else begin
      if (en1_i) begin
        a1_q <= clr1_i ? '0 : a_i;
        b1_q <= clr1_i ? '0 : b_i;
        r1_q <= clr1_i ? '0 : r1_d;
        v1_q <= clr1_i ? '0 : v1_d;
      end
      if (en2_i) begin
        p2_q <= clr2_i ? '0 : p2_d;
        u2_q <= clr2_i ? '0 : u2_d;
        w2_q <= clr2_i ? '0 : w2_d;
      end
    end
  end
endmodule

// File: rtl/msk_and_pini_lanes.sv
// msk_and_pini_lanes: N-lane d-share PINI masked AND with valid/ready flow control.
// Define MSK_AND_CLR_ON_IDLE_EN to zero stage data on bubbles so out reads 0 while out_valid is low.
module msk_and_pini_lanes
  import msk_and_pini_lanes_pkg::*;
#(
  parameter int D = 2,
  parameter int N = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  msk_and_pini_lanes_if.slave io
);
  localparam int NRND = msk_nrnd(D);
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic adv1, adv2, en1, en2, clr1, clr2;
  logic [N*D-1:0] out_w;
  assign adv2 = ~s2_valid_q | io.out_ready;
  assign adv1 = ~s1_valid_q | adv2;
  assign io.in_ready = adv1;
  assign io.out_valid = s2_valid_q;
  assign io.out = out_w;
  assign s1_valid_d = adv1 ? io.in_valid : s1_valid_q;
  assign s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
`ifdef MSK_AND_CLR_ON_IDLE_EN
  assign en1 = adv1;
  assign clr1 = ~io.in_valid;
  assign en2 = adv2;
  assign clr2 = ~s1_valid_q;
`else
  assign en1 = adv1 & io.in_valid;
  assign clr1 = 1'b0;
  assign en2 = adv2 & s1_valid_q;
  assign clr2 = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end
  for (genvar l = 0; l < N; l++) begin : g_lane
    msk_and_pini_lanes_lane #(.D(D)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en1_i  (en1),
      .en2_i  (en2),
      .clr1_i (clr1),
      .clr2_i (clr2),
      .a_i    (io.ina[l*D +: D]),
      .b_i    (io.inb[l*D +: D]),
      .r_i    (io.rnd[l*NRND +: NRND]),
      .out_o  (out_w[l*D +: D])
    );
  end
endmodule

// File: tb/tb_msk_and_pini_lanes.sv
// tb_msk_and_pini_lanes: random-stimulus bench for the masked AND lanes (D=2,N=4 and D=3,N=1)
module tb_msk_and_pini_lanes;
  localparam int D = 2, N = 4, NR = 1, W = N * D, WR = N * NR;
  localparam int D3 = 3, NR3 = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  int errs = 0, checks = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  msk_and_pini_lanes_if #(.D(D), .N(N)) bus();
  msk_and_pini_lanes_if #(.D(D3), .N(1)) bus3();
  msk_and_pini_lanes #(.D(D), .N(N)) dut (.clk(clk), .rst_n(rst_n), .io(bus.slave));
  msk_and_pini_lanes #(.D(D3), .N(1)) dut3 (.clk(clk), .rst_n(rst_n), .io(bus3.slave));
  logic [N-1:0] sb_q[$];
  int sb_t[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [N-1:0] ref_and(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [N-1:0] r;
    for (int l = 0; l < N; l++) r[l] = (^a[l*D +: D]) & (^b[l*D +: D]);
    return r;
  endfunction
  function automatic logic [N-1:0] unmask(input logic [W-1:0] o);
    logic [N-1:0] r;
    for (int l = 0; l < N; l++) r[l] = ^o[l*D +: D];
    return r;
  endfunction
  // pipeline of depth 2: ready unless both slots are occupied and the consumer stalls
  task automatic step(input logic v, input logic ordy, input logic [W-1:0] a, input logic [W-1:0] b, input bit lat);
    int t;
    @(negedge clk);
    bus.in_valid = v;
    bus.ina = a;
    bus.inb = b;
    bus.rnd = WR'($urandom);
    bus.out_ready = ordy;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'((sb_q.size() < 2) || ordy));
    if (bus.out_valid && ordy) begin
      if (sb_q.size() == 0) chk("spurious_out", 32'(bus.out_valid), 32'd0);
      else begin
        chk("lane_and", 32'(unmask(bus.out)), 32'(sb_q.pop_front()));
        t = sb_t.pop_front();
        if (lat) chk("latency", 32'(cyc - t), 32'd2);
      end
    end
    if (v && bus.in_ready) begin
      sb_q.push_back(ref_and(a, b));
      sb_t.push_back(cyc);
    end
  endtask
  function automatic logic [W-1:0] rw();
    return W'($urandom);
  endfunction
  initial begin
    logic [W-1:0] a, b, held;
    logic [3:0] c;
    logic [D3-1:0] a3, b3, prev3;
    logic [NR3-1:0] r3;
    logic [D3-1:0] mtbl[NR3];
    logic e3_q[$];
    logic [D3-1:0] m3_q[$];
    int k3;
    bus.in_valid = 0; bus.ina = '0; bus.inb = '0; bus.rnd = '0; bus.out_ready = 1;
    bus3.in_valid = 0; bus3.ina = '0; bus3.inb = '0; bus3.rnd = '0; bus3.out_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1;
    // exhaustive share combos, a different combo on each lane
    for (int k = 0; k < 16; k++) begin
      for (int l = 0; l < N; l++) begin
        c = 4'((k + 5 * l) & 15);
        a[l*D +: D] = c[1:0];
        b[l*D +: D] = c[3:2];
      end
      step(1, 1, a, b, 1);
    end
    for (int k = 0; k < 8; k++) step(1, 1, rw(), rw(), 1);
    repeat (3) step(0, 1, rw(), rw(), 1);
    chk("drain_b2b", 32'(sb_q.size()), 32'd0);
    // stall with a full pipe
    held = '0;
    for (int k = 0; k < 5; k++) begin
      step(1, 0, rw(), rw(), 0);
      chk("stall_valid", 32'(bus.out_valid), 32'(k >= 2));
      if (k == 2) held = bus.out;
      if (k > 2) chk("stall_hold", 32'(bus.out), 32'(held));
    end
    for (int k = 0; k < 4; k++) step(1, 1, rw(), rw(), 0);
    repeat (3) step(0, 1, rw(), rw(), 0);
    chk("drain_stall", 32'(sb_q.size()), 32'd0);
    // reset with two beats in flight
    step(1, 1, rw(), rw(), 0);
    step(1, 1, rw(), rw(), 0);
    @(negedge clk);
    bus.in_valid = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out", 32'(bus.out), 32'd0);
    sb_q.delete();
    sb_t.delete();
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      step(0, 1, rw(), rw(), 0);
      chk("no_stale", 32'(bus.out_valid), 32'd0);
    end
    // alternating beats and bubbles, then fully random flow control
    for (int k = 0; k < 16; k++) begin
      step(1'(k % 2), 1, rw(), rw(), 1);
`ifdef MSK_AND_CLR_ON_IDLE_EN
      if (!bus.out_valid) chk("idle_zero", 32'(bus.out), 32'd0);
`endif
    end
    for (int k = 0; k < 200; k++) begin
      step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), rw(), rw(), 0);
`ifdef MSK_AND_CLR_ON_IDLE_EN
      if (!bus.out_valid) chk("idle_zero", 32'(bus.out), 32'd0);
`endif
    end
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) step(0, 1, rw(), rw(), 0);
    chk("drain_rand", 32'(sb_q.size()), 32'd0);
    // D=3: correctness plus which shares each random bit reaches
    k3 = 0;
    for (int i = 0; i < D3; i++)
      for (int j = i + 1; j < D3; j++) begin
        mtbl[k3] = D3'((1 << i) | (1 << j));
        k3++;
      end
    prev3 = '0; a3 = '0; b3 = '0; r3 = '0;
    for (int k = 0; k < 304; k++) begin
      int idx;
      @(negedge clk);
      bus3.in_valid = k < 300;
      if (k % 2 == 0) begin
        a3 = D3'($urandom); b3 = D3'($urandom); r3 = NR3'($urandom);
      end else begin
        idx = $urandom_range(NR3 - 1, 0);
        r3 = r3 ^ NR3'(1 << idx);
      end
      bus3.ina = a3; bus3.inb = b3; bus3.rnd = r3;
      #1;
      if (bus3.out_valid) begin
        if (e3_q.size() == 0) chk("d3_spurious", 32'(bus3.out_valid), 32'd0);
        else begin
          logic [D3-1:0] m;
          chk("d3_and", 32'(^bus3.out), 32'(e3_q.pop_front()));
          m = m3_q.pop_front();
          if (m != 0) chk("d3_rdiff", 32'(bus3.out ^ prev3), 32'(m));
          prev3 = bus3.out;
        end
      end
      if (k < 300) begin
        e3_q.push_back((^a3) & (^b3));
        m3_q.push_back(k % 2 == 0 ? D3'(0) : mtbl[idx]);
      end
    end
    chk("d3_drain", 32'(e3_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
